hysteresis_threshold_stream: RTL and testbench

- Streaming successor to the frame-parallel double-threshold stage of the Canny edge pipeline.
- Accepts a raster-order pixel stream from non-max suppression and classifies each pixel as strong, weak or zero against runtime thresholds latched per frame.
- Mode 1 adds single-pass 8-neighbour hysteresis using two line buffers.
- Emits a raster-order result stream with valid/ready backpressure and a per-frame done pulse.

---
 rtl/hysteresis_threshold_stream.sv | 246 ++++++++++++++++++++++++
 tb/tb_hysteresis_threshold_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hysteresis_threshold_stream.sv
// hysteresis_threshold_stream
// Streaming double-threshold / hysteresis stage for a Canny edge pipeline.
// Classifies a raster-order pixel stream as strong, weak or zero against
// thresholds latched at start. Mode 0 maps classes directly to output
// levels. Mode 1 promotes a weak pixel to strong when any of its 8
// neighbours is strong, in a single pass.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i                 begin a frame (IDLE only); latches thresholds/mode
//   high_thr_i, low_thr_i   strong / weak thresholds
//   mode_i                  0 = plain threshold, 1 = hysteresis
//   in_data_i/valid/ready   input pixel stream
//   out_data_o/valid/ready  result pixel stream
//   busy_o                  frame in progress
//   done_o                  one-cycle pulse after the last output handshake
//
// State table:
//   S_IDLE   | waiting for start
//   S_STREAM | accepting the frame's pixels
//   S_FLUSH  | all inputs taken, draining the remaining outputs
//   S_DONE   | done pulse, back to idle next cycle
module hysteresis_threshold_stream #(
  parameter int DATA_W       = 8,
  parameter int HEIGHT       = 5,
  parameter int WIDTH        = 5,
  parameter int WEAK_PIXEL   = 75,
  parameter int STRONG_PIXEL = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] high_thr_i,
  input  logic [DATA_W-1:0] low_thr_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int N      = HEIGHT * WIDTH;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int COL_W  = $clog2(WIDTH);
  localparam int LAG    = WIDTH + 1;
  // Class history: two rows plus two pixels behind the newest push.
  localparam int HIST_D = 2 * WIDTH + 2;

  localparam logic [1:0] CLS_ZERO   = 2'd0;
  localparam logic [1:0] CLS_WEAK   = 2'd1;
  localparam logic [1:0] CLS_STRONG = 2'd2;

  localparam logic [DATA_W-1:0] WEAK_V   = DATA_W'(WEAK_PIXEL);
  localparam logic [DATA_W-1:0] STRONG_V = DATA_W'(STRONG_PIXEL);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [DATA_W-1:0]          high_q, high_d;
  logic [DATA_W-1:0]          low_q, low_d;
  logic                       mode_q, mode_d;
  logic [CNT_W-1:0]           in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]           out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]           gen_cnt_q, gen_cnt_d;
  logic [ROW_W-1:0]           gen_row_q, gen_row_d;
  logic [COL_W-1:0]           gen_col_q, gen_col_d;
  logic [HIST_D-1:0][1:0]     hist_q, hist_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  function automatic logic [1:0] classify(input logic [DATA_W-1:0] px,
                                          input logic [DATA_W-1:0] hi,
                                          input logic [DATA_W-1:0] lo);
    // With lo > hi nothing can satisfy lo <= px < hi, so the weak band is empty.
    if (px >= hi)      return CLS_STRONG;
    else if (px >= lo) return CLS_WEAK;
    else               return CLS_ZERO;
  endfunction

  logic       slot_free;
  logic       in_ready;
  logic       in_fire;
  logic       out_fire;
  logic       flush_push;
  logic       push;
  logic [1:0] push_cls;
  logic       gen;
  logic       top_ok, bot_ok, left_ok, right_ok;
  logic       strong_nb;
  logic [1:0] ctr_cls;
  logic [DATA_W-1:0] gen_pixel;

  assign slot_free  = !out_valid_q || out_ready_i;
  assign in_ready   = (state_q == S_STREAM) && (in_cnt_q != CNT_W'(N)) && slot_free;
  assign in_fire    = in_valid_i && in_ready;
  assign out_fire   = out_valid_q && out_ready_i;
  // After the last real pixel, zero classes are pushed to release the
  // trailing WIDTH+1 hysteresis results.
  assign flush_push = (state_q == S_FLUSH) && mode_q && (gen_cnt_q != CNT_W'(N)) && slot_free;
  assign push       = in_fire || flush_push;
  assign push_cls   = in_fire ? classify(in_data_i, high_q, low_q) : CLS_ZERO;
  assign gen        = mode_q ? (flush_push || (in_fire && (in_cnt_q >= CNT_W'(LAG)))) : in_fire;

  // The result being generated sits WIDTH+1 pushes behind the newest one.
  // Neighbour offsets (newest = push_cls): br 0, b 1, bl 2, r W, c W+1,
  // l W+2, tr 2W, t 2W+1, tl 2W+2; hist_q[i] holds offset i+1.
  assign top_ok   = (gen_row_q != '0);
  assign bot_ok   = (gen_row_q != ROW_W'(HEIGHT - 1));
  assign left_ok  = (gen_col_q != '0);
  assign right_ok = (gen_col_q != COL_W'(WIDTH - 1));
  assign ctr_cls  = hist_q[WIDTH];

  assign strong_nb =
      (top_ok && left_ok  && (hist_q[2*WIDTH+1] == CLS_STRONG)) ||
      (top_ok             && (hist_q[2*WIDTH]   == CLS_STRONG)) ||
      (top_ok && right_ok && (hist_q[2*WIDTH-1] == CLS_STRONG)) ||
      (left_ok            && (hist_q[WIDTH+1]   == CLS_STRONG)) ||
      (right_ok           && (hist_q[WIDTH-1]   == CLS_STRONG)) ||
      (bot_ok && left_ok  && (hist_q[1]         == CLS_STRONG)) ||
      (bot_ok             && (hist_q[0]         == CLS_STRONG)) ||
      (bot_ok && right_ok && (push_cls          == CLS_STRONG));

  always_comb begin
    gen_pixel = '0;
    if (mode_q) begin
      if (ctr_cls == CLS_STRONG)                   gen_pixel = STRONG_V;
      else if (ctr_cls == CLS_WEAK && strong_nb)   gen_pixel = STRONG_V;
    end else begin
      if (push_cls == CLS_STRONG)                  gen_pixel = STRONG_V;
      else if (push_cls == CLS_WEAK)               gen_pixel = WEAK_V;
    end
  end

  always_comb begin
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    mode_d      = mode_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    gen_cnt_d   = gen_cnt_q;
    gen_row_d   = gen_row_q;
    gen_col_d   = gen_col_q;
    hist_d      = hist_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (in_fire)  in_cnt_d  = in_cnt_q + CNT_W'(1);
    if (out_fire) out_cnt_d = out_cnt_q + CNT_W'(1);
    if (push)     hist_d    = {hist_q[HIST_D-2:0], push_cls};

    if (gen) begin
      out_valid_d = 1'b1;
      out_data_d  = gen_pixel;
      gen_cnt_d   = gen_cnt_q + CNT_W'(1);
      if (gen_col_q == COL_W'(WIDTH - 1)) begin
        gen_col_d = '0;
        gen_row_d = (gen_row_q == ROW_W'(HEIGHT - 1)) ? '0 : gen_row_q + ROW_W'(1);
      end else begin
        gen_col_d = gen_col_q + COL_W'(1);
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_STREAM;
          high_d    = high_thr_i;
          low_d     = low_thr_i;
          mode_d    = mode_i;
          busy_d    = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          gen_cnt_d = '0;
          gen_row_d = '0;
          gen_col_d = '0;
          hist_d    = '0;
        end
      end
      S_STREAM: begin
        if (in_fire && (in_cnt_q == CNT_W'(N - 1))) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (out_fire && (out_cnt_q == CNT_W'(N - 1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      high_q      <= '0;
      low_q       <= '0;
      mode_q      <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      gen_cnt_q   <= '0;
      gen_row_q   <= '0;
      gen_col_q   <= '0;
      hist_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      low_q       <= low_d;
      mode_q      <= mode_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      gen_cnt_q   <= gen_cnt_d;
      gen_row_q   <= gen_row_d;
      gen_col_q   <= gen_col_d;
      hist_q      <= hist_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_hysteresis_threshold_stream.sv
// Self-checking bench for hysteresis_threshold_stream (5x5 frames).
module tb_hysteresis_threshold_stream;

  localparam int H = 5;
  localparam int W = 5;
  localparam int N = H * W;

  logic       clk = 1'b0;
  logic       reset, start, mode, in_valid, out_ready;
  logic [7:0] high_thr, low_thr, in_data;
  logic       in_ready, out_valid, busy, done;
  logic [7:0] out_data;

  int pix[N];
  int expv[N];
  int got[N];
  int acc_cyc[N];
  int vectors = 0;
  int miscompares = 0;
  int acc, cyc;

  hysteresis_threshold_stream #(
    .DATA_W(8), .HEIGHT(H), .WIDTH(W), .WEAK_PIXEL(75), .STRONG_PIXEL(255)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .high_thr_i(high_thr), .low_thr_i(low_thr), .mode_i(mode),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: classify the whole frame, then apply the output rule per pixel.
  task automatic model(input int md, input int hi, input int lo);
    int cls[H][W];
    int e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int p = pix[r*W + c];
        if (p >= hi)                cls[r][c] = 2;
        else if (p >= lo && p < hi) cls[r][c] = 1;
        else                        cls[r][c] = 0;
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e = 0;
        if (cls[r][c] == 2) e = 255;
        else if (cls[r][c] == 1) begin
          if (md == 0) e = 75;
          else
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < H &&
                    c+dc >= 0 && c+dc < W && cls[r+dr][c+dc] == 2)
                  e = 255;
        end
        expv[r*W + c] = e;
      end
  endtask

  task automatic run_frame(input int md, input int hi, input int lo,
                           input int gap, input int stall);
    int ii, oi, dones, fc, src;
    logic prev_stall, noted;
    logic [7:0] prev_data;
    model(md, hi, lo);
    for (int k = 0; k < N; k++) begin acc_cyc[k] = -10; got[k] = -1; end
    @(negedge clk);
    start = 1'b1; high_thr = 8'(hi); low_thr = 8'(lo); mode = md[0];
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // Scramble config after start: it must not affect this frame.
    high_thr = 8'($urandom); low_thr = 8'($urandom); mode = 1'($urandom);
    #1 chk("busy_after_start", busy, 1);
    ii = 0; oi = 0; dones = 0; fc = 0; prev_stall = 1'b0; noted = 1'b0; prev_data = '0;
    while (dones == 0 && fc < 2000) begin
      in_valid  = (ii < N) && ($urandom_range(99) >= gap);
      in_data   = (ii < N) ? 8'(pix[ii]) : 8'h00;
      out_ready = ($urandom_range(99) >= stall);
      #1;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (done) begin
        dones++;
        chk("done_after_all_outputs", oi, N);
      end
      if (out_valid && !noted) begin
        noted = 1'b1;
        src = (md == 0) ? oi : oi + W + 1;
        if (src < N) chk("latency", fc, acc_cyc[src] + 1);
      end
      if (out_valid && out_ready) begin
        if (oi < N) begin
          got[oi] = out_data;
          chk($sformatf("out[%0d]", oi), out_data, expv[oi]);
        end
        oi++;
        noted = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc_cyc[ii] = fc;
        ii++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
      fc++;
    end
    in_valid = 1'b0;
    chk("done_seen", dones, 1);
    chk("inputs_accepted", ii, N);
    chk("output_handshakes", oi, N);
    #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("out_valid_idle", out_valid, 0);
  endtask

  task automatic clear_pix();
    for (int k = 0; k < N; k++) pix[k] = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    high_thr = '0; low_thr = '0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;

    // Mode 0: zero border, ring of 100, centre 255.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix[r*W+c] = (r == 0 || r == H-1 || c == 0 || c == W-1) ? 0 :
                     (r == 2 && c == 2) ? 255 : 100;
    run_frame(0, 38, 2, 0, 0);
    chk("ringA_border", got[0], 0);
    chk("ringA_ring", got[6], 255);
    chk("ringA_centre", got[12], 255);

    // Mode 0 band edges.
    for (int k = 0; k < N; k++) pix[k] = $urandom_range(255);
    pix[0] = 1; pix[1] = 2; pix[2] = 37; pix[3] = 38;
    run_frame(0, 38, 2, 0, 0);
    chk("edge_1", got[0], 0);
    chk("edge_2", got[1], 75);
    chk("edge_37", got[2], 75);
    chk("edge_38", got[3], 255);

    // Mode 1 basic hysteresis.
    clear_pix();
    pix[12] = 200; pix[13] = 20; pix[0] = 20;
    run_frame(1, 38, 2, 0, 0);
    chk("hyst_strong", got[12], 255);
    chk("hyst_weak_promoted", got[13], 255);
    chk("hyst_corner_weak", got[0], 0);

    // Mode 1 under backpressure and input gaps; frame ends on a strong pixel.
    for (int k = 0; k < N; k++) pix[k] = $urandom_range(255);
    pix[N-1] = 255;
    run_frame(1, 120, 60, 30, 40);

    // Mode 1 wrap-around: strong pixels adjacent only through row/column wrap.
    clear_pix();
    pix[0] = 20; pix[5] = 20; pix[4] = 200; pix[20] = 200; pix[24] = 200; pix[19] = 20;
    run_frame(1, 38, 2, 0, 0);
    chk("wrap_corner", got[0], 0);
    chk("wrap_row_start", got[5], 0);
    chk("wrap_real_neighbour", got[19], 255);

    // Reset after 12 accepted inputs.
    for (int k = 0; k < N; k++) pix[k] = $urandom_range(255);
    @(negedge clk);
    start = 1'b1; high_thr = 8'd38; low_thr = 8'd2; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0; cyc = 0; out_ready = 1'b1;
    while (acc < 12 && cyc < 200) begin
      in_valid = 1'b1; in_data = 8'(pix[acc]);
      #1;
      if (in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    chk("pre_reset_inputs", acc, 12);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk("midrst_no_done", done, 0);
    end
    run_frame(0, 90, 30, 10, 20);

    // Inverted thresholds: empty weak band, both modes.
    clear_pix();
    pix[6] = 45; pix[8] = 39; pix[16] = 45;
    run_frame(0, 40, 50, 0, 0);
    chk("inv_m0_45", got[6], 255);
    chk("inv_m0_39", got[8], 0);
    run_frame(1, 40, 50, 0, 0);
    chk("inv_m1_45", got[6], 255);
    chk("inv_m1_39", got[8], 0);

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < N; k++) pix[k] = $urandom_range(255);
      run_frame(f % 2, $urandom_range(255), $urandom_range(255),
                $urandom_range(50), $urandom_range(60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
